// File: rtl/seven_segment_capture_if.sv
// Display-bus interface for seven_segment_capture.
// The master side drives the scanned segment/anode lines and observes the
// decoded results; the slave side is the capture block itself.
interface seven_segment_capture_if;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic [3:0]  bad_glyph;
   logic [3:0]  updated;
   logic        all_valid;
   logic [6:0]  value_bin;

   modport master (
      output seg, an,
      input  digits, blank, bad_glyph, updated, all_valid, value_bin
   );

   modport slave (
      input  seg, an,
      output digits, blank, bad_glyph, updated, all_valid, value_bin
   );
endinterface

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: samples a multiplexed 4-digit 7-segment bus,
// filters scan transitions, decodes each glyph back to hex per digit
// position and forms position1*10 + position0 as a binary value.
// Optional macro CAPTURE_TIMEOUT_EN adds per-position staleness timeout.
module seven_segment_capture #(
   parameter int STABLE_CYCLES  = 16,
   parameter int AN_ACTIVE_LOW  = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seven_segment_capture_if.slave bus
);

   localparam logic [15:0] STABLE_V  = 16'(STABLE_CYCLES);
   localparam logic [15:0] STABLE_M1 = 16'(STABLE_CYCLES - 1);

   // Glyph decode on the lit pattern gfedcba; returns {hit, value}
   function automatic logic [4:0] f_decode(input logic [6:0] lit);
      case (lit)
         7'b0111111: return {1'b1, 4'h0};
         7'b0000110: return {1'b1, 4'h1};
         7'b1011011: return {1'b1, 4'h2};
         7'b1001111: return {1'b1, 4'h3};
         7'b1100110: return {1'b1, 4'h4};
         7'b1101101: return {1'b1, 4'h5};
         7'b1111101: return {1'b1, 4'h6};
         7'b0000111: return {1'b1, 4'h7};
         7'b0100111: return {1'b1, 4'h7};
         7'b1111111: return {1'b1, 4'h8};
         7'b1101111: return {1'b1, 4'h9};
         7'b1100111: return {1'b1, 4'h9};
         7'b1110111: return {1'b1, 4'hA};
         7'b1111100: return {1'b1, 4'hB};
         7'b0111001: return {1'b1, 4'hC};
         7'b1011110: return {1'b1, 4'hD};
         7'b1111001: return {1'b1, 4'hE};
         7'b1110001: return {1'b1, 4'hF};
         default:    return 5'b0_0000;
      endcase
   endfunction

   // Two-digit decimal value; blank or non-decimal digits count as zero
   function automatic logic [6:0] f_bin(input logic [3:0] d1, input logic b1,
                                        input logic [3:0] d0, input logic b0);
      logic [3:0] v1;
      logic [3:0] v0;
      v1 = (b1 || (d1 > 4'd9)) ? 4'd0 : d1;
      v0 = (b0 || (d0 > 4'd9)) ? 4'd0 : d0;
      return (7'(v1) * 7'd10) + 7'(v0);
   endfunction

   logic [6:0]  r_seg_s1, r_seg_s2;
   logic [3:0]  r_an_s1, r_an_s2;
   logic [10:0] r_prev;
   logic [15:0] r_cnt;
   logic        r_commit;
   logic [3:0]  r_cmt_an;
   logic [6:0]  r_cmt_seg;
   logic [15:0] r_digits;
   logic [3:0]  r_blank;
   logic [3:0]  r_bad;
   logic [3:0]  r_updated;
   logic [3:0]  r_seen;
   logic        r_all_valid;
   logic [6:0]  r_value_bin;

   logic [3:0]  w_an;
   logic [6:0]  w_seg;
   logic [10:0] w_sample;
   logic        w_onehot;
   logic        w_same;
   logic        w_hit;
   logic [4:0]  w_dec;

   // Polarity normalisation: internally 1 means anode active / segment lit
   assign w_an     = (AN_ACTIVE_LOW  != 0) ? ~r_an_s2  : r_an_s2;
   assign w_seg    = (SEG_ACTIVE_LOW != 0) ? ~r_seg_s2 : r_seg_s2;
   assign w_sample = {w_an, w_seg};
   assign w_onehot = $onehot(w_an);
   assign w_same   = (w_sample == r_prev);
   assign w_hit    = w_onehot && w_same && (r_cnt == STABLE_M1);
   assign w_dec    = f_decode(r_cmt_seg);

   // Two-flop synchroniser on the raw bus lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_s1 <= '0;
         r_seg_s2 <= '0;
         r_an_s1  <= '0;
         r_an_s2  <= '0;
      end else begin
         r_seg_s1 <= bus.seg;
         r_seg_s2 <= r_seg_s1;
         r_an_s1  <= bus.an;
         r_an_s2  <= r_an_s1;
      end
   end

   // Stability counter: saturates at STABLE_CYCLES so a frame commits once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev    <= '0;
         r_cnt     <= '0;
         r_commit  <= 1'b0;
         r_cmt_an  <= '0;
         r_cmt_seg <= '0;
      end else begin
         r_prev    <= w_sample;
         r_commit  <= w_hit;
         r_cmt_an  <= w_an;
         r_cmt_seg <= w_seg;
         if (!w_onehot)
            r_cnt <= '0;
         else if (!w_same)
            r_cnt <= 16'd1;
         else if (r_cnt != STABLE_V)
            r_cnt <= r_cnt + 16'd1;
      end
   end

`ifdef CAPTURE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_V  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT_CYCLES - 1);
   logic [3:0][TW-1:0] r_to_cnt;
`endif

   // Commit stage: update the addressed digit slot and its status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digits  <= '0;
         r_blank   <= 4'hF;
         r_bad     <= '0;
         r_updated <= '0;
         r_seen    <= '0;
`ifdef CAPTURE_TIMEOUT_EN
         r_to_cnt  <= '0;
`endif
      end else begin
         r_updated <= r_commit ? r_cmt_an : 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if (r_commit && r_cmt_an[i]) begin
               r_seen[i] <= 1'b1;
               if (r_cmt_seg == 7'b0000000) begin
                  r_digits[4*i +: 4] <= 4'h0;
                  r_blank[i]         <= 1'b1;
                  r_bad[i]           <= 1'b0;
               end else if (w_dec[4]) begin
                  r_digits[4*i +: 4] <= w_dec[3:0];
                  r_blank[i]         <= 1'b0;
                  r_bad[i]           <= 1'b0;
               end else begin
                  r_blank[i]         <= 1'b0;
                  r_bad[i]           <= 1'b1;
               end
`ifdef CAPTURE_TIMEOUT_EN
               r_to_cnt[i] <= '0;
            end else if (r_to_cnt[i] != TO_V) begin
               r_to_cnt[i] <= r_to_cnt[i] + 1'b1;
               if (r_to_cnt[i] == TO_M1) begin
                  r_seen[i]  <= 1'b0;
                  r_blank[i] <= 1'b1;
               end
`endif
            end
         end
      end
   end

   // Summary outputs: all-valid flag and two-digit binary value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_all_valid <= 1'b0;
         r_value_bin <= '0;
      end else begin
         r_all_valid <= &r_seen;
         if (r_updated[0] || r_updated[1])
            r_value_bin <= f_bin(r_digits[7:4], r_blank[1], r_digits[3:0], r_blank[0]);
      end
   end

   assign bus.digits    = r_digits;
   assign bus.blank     = r_blank;
   assign bus.bad_glyph = r_bad;
   assign bus.updated   = r_updated;
   assign bus.all_valid = r_all_valid;
   assign bus.value_bin = r_value_bin;

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
Receiver for the multiplexed 7-segment display bus (4 anodes, 7 segment lines) driven by the display scanner. Samples the bus, filters scan transitions, decodes each glyph back to a 4-bit hex value per digit position, and builds a binary value from the two low digits. Used for on-board self-check of the display path and for bench scoreboarding of display output.

Parameters:
STABLE_CYCLES, 16, consecutive identical samples required before a digit is committed (range 2..65535)
AN_ACTIVE_LOW, 1, 1: anode asserted when bit is 0; 0: asserted when 1
SEG_ACTIVE_LOW, 1, 1: segment lit when bit is 0; 0: lit when 1
TIMEOUT_CYCLES, 1048576, staleness limit per digit (used only with CAPTURE_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg  input  7  segment lines, seg[0]=a ... seg[6]=g
an  input  4  anode lines, an[i] selects digit position i
digits  output  16  committed hex values, digits[4i+3:4i] = position i
blank  output  4  blank[i]=1: position i last committed all-segments-off
bad_glyph  output  4  bad_glyph[i]=1: position i last committed a non-hex pattern
updated  output  4  one-cycle pulse on commit of position i
all_valid  output  1  every position committed at least once since reset
value_bin  output  7  position1*10 + position0 (0..99), registered

Behaviour:
- Reset (async, rst_n=0): digits=0, blank=4'hF, bad_glyph=0, updated=0, all_valid=0, value_bin=0, stability counter=0, seen mask=0.
- Input stage: seg/an pass through a 2-flop synchroniser; normalise polarity per parameters so internally 1 = active/lit.
- Frame qualification: a sample is a frame only if exactly one anode active (one-hot). Zero or multiple active anodes: counter cleared, nothing committed.
- Stability: counter increments while {an,seg} equals the previous cycle's sample; any change reloads it to 1. When the count reaches STABLE_CYCLES on a qualified frame, commit once; no further commit until {an,seg} changes. Counter saturates, never wraps.
- Decode (lit pattern gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. Also accept 7 with segment f (0100111) and 9 without d (1100111).
- Commit to position i: all-off -> digits slot=0, blank[i]=1, bad_glyph[i]=0; table hit -> slot=value, blank[i]=0, bad_glyph[i]=0; otherwise slot unchanged, bad_glyph[i]=1, blank[i]=0. updated[i] pulses the cycle after the commit decision; seen[i] set.
- all_valid = &seen, registered.
- value_bin: recomputed the cycle after any commit to position 0 or 1; slot value >9 or blank is treated as 0 for the arithmetic. Result width 7 bits, max 99.
- Latency: bus change to updated pulse = 2 (sync) + STABLE_CYCLES + 1 cycles; value_bin follows updated by 1 cycle.
- Reset mid-frame: all state cleared immediately; first commit needs a full STABLE_CYCLES window after release.

Optional Feature:
CAPTURE_TIMEOUT_EN: when defined, each position has a counter cleared on its commit and saturating at TIMEOUT_CYCLES; on reaching it, seen[i] is cleared (all_valid drops) and blank[i] is set; digits slot is retained. When undefined, no timeout logic; seen bits stay set until reset.

Test Plan:
- Reset: hold rst_n=0 with random bus -> digits=0, blank=F, all_valid=0, updated=0.
- Scan an=1110, seg=1000000 (active-low "0"), an=1101 seg=1111001 ("1"), 131072-cycle dwell each, STABLE_CYCLES=16 -> digits[3:0]=0, digits[7:4]=1, value_bin=10, one updated pulse per position per dwell.
- Ghosting: toggle an between 1110 and 1100 every 3 cycles -> no commits, updated stays 0.
- Glitch: stable "8" for 10 cycles then seg change, STABLE_CYCLES=16 -> no commit; then stable 16 cycles -> exactly one commit, value 8.
- Bad glyph seg pattern lit 0001001 on position 2 -> bad_glyph[2]=1, digits[11:8] unchanged; then valid "A" -> bad_glyph[2]=0, slot=A.
- With CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=1000: all four positions refreshed then position 3 idle 1000 cycles -> all_valid falls, blank[3]=1; without macro all_valid stays 1.
